// File: rtl/pe_pkg.sv
// Shared definitions for the PE column datapath: default widths, drain FSM states
// and the ReLU / shift / saturate transform applied to accumulated partial sums.
package pe_pkg;

    localparam int PE_DATA_WIDTH = 8;
    localparam int PE_PSUM_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Works on a sign-extended 64-bit psum so any PSUM_WIDTH up to 64 can share it.
    function automatic logic [31:0] relu_shift_sat(input logic signed [63:0] psum,
                                                   input logic [4:0]         shift,
                                                   input int                 data_width);
        logic [63:0] x;
        logic [63:0] max_val;
        x       = psum[63] ? 64'd0 : psum;
        x       = x >> shift;
        max_val = (64'd1 << data_width) - 64'd1;
        if (x > max_val) begin
            x = max_val;
        end
        return x[31:0];
    endfunction

endpackage

// File: rtl/psum_buf.sv
// DEPTH x PSUM_WIDTH register file: one synchronous write port, one combinational
// read port. Contents are not reset; the first pass of every job overwrites them.
module psum_buf #(
    parameter int DEPTH      = 16,
    parameter int PSUM_WIDTH = 32,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [PSUM_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [PSUM_WIDTH-1:0] rd_data
);

    logic [PSUM_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/psum_drain.sv
// Accumulates PE-column psums over several passes, then drains ReLU/shift/saturated
// values through a registered valid/ready port (1-cycle load, holds under backpressure).
module psum_drain
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = PE_DATA_WIDTH,
    parameter int PSUM_WIDTH = PE_PSUM_WIDTH,
    parameter int DEPTH      = 16,
    parameter int PASS_W     = 4,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start_i,
    input  logic [AW-1:0]         cfg_len_i,
    input  logic [PASS_W-1:0]     cfg_passes_i,
    input  logic [4:0]            cfg_shift_i,
    input  logic [PSUM_WIDTH-1:0] psum_i,
    input  logic                  psum_en_i,
    output logic [DATA_WIDTH-1:0] ofmap_o,
    output logic                  ofmap_valid_o,
    input  logic                  ofmap_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    state_t state, state_n;

    logic [AW-1:0]     len_q;
    logic [PASS_W-1:0] passes_q;
    logic [4:0]        shift_q;
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [PASS_W-1:0] pass;
    logic              rd_all;

    logic                         start;
    logic                         wr_en;
    logic                         load;
    logic                         finish;
    logic [AW-1:0]                rd_addr;
    logic signed [PSUM_WIDTH-1:0] rd_data;
    logic [PSUM_WIDTH-1:0]        wr_data;
    logic [DATA_WIDTH-1:0]        ofmap_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        start   = 1'b0;
        wr_en   = 1'b0;
        load    = 1'b0;
        finish  = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_start_i) begin
                    start   = 1'b1;
                    state_n = ACCUM;
                end
            end
            ACCUM: begin
                if (psum_en_i) begin
                    wr_en = 1'b1;
                    if (wptr == len_q && pass == passes_q) begin
                        state_n = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // rd_all marks that entry len is already in the output register.
                load = !rd_all && (!ofmap_valid_o || ofmap_ready_i);
                if (rd_all && ofmap_valid_o && ofmap_ready_i) begin
                    finish  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign rd_addr = (state == DRAIN) ? rptr : wptr;
    assign wr_data = (pass == '0) ? psum_i : rd_data + psum_i;
    assign ofmap_d = DATA_WIDTH'(relu_shift_sat(64'(rd_data), shift_q, DATA_WIDTH));
    assign busy_o  = (state != IDLE);

    psum_buf #(
        .DEPTH      (DEPTH),
        .PSUM_WIDTH (PSUM_WIDTH),
        .AW         (AW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wptr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q         <= '0;
            passes_q      <= '0;
            shift_q       <= '0;
            wptr          <= '0;
            rptr          <= '0;
            pass          <= '0;
            rd_all        <= 1'b0;
            ofmap_o       <= '0;
            ofmap_valid_o <= 1'b0;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            done_o <= finish;

            // A start in the same cycle as a stray psum still clears the error.
            if (start) begin
                len_q    <= cfg_len_i;
                passes_q <= cfg_passes_i;
                shift_q  <= cfg_shift_i;
                wptr     <= '0;
                rptr     <= '0;
                pass     <= '0;
                rd_all   <= 1'b0;
                err_o    <= 1'b0;
            end else if (psum_en_i && state != ACCUM) begin
                err_o <= 1'b1;
            end

            if (wr_en) begin
                if (wptr == len_q) begin
                    wptr <= '0;
                    pass <= pass + PASS_W'(1);
                end else begin
                    wptr <= wptr + AW'(1);
                end
            end

            if (load) begin
                ofmap_o       <= ofmap_d;
                ofmap_valid_o <= 1'b1;
                if (rptr == len_q) begin
                    rd_all <= 1'b1;
                end else begin
                    rptr <= rptr + AW'(1);
                end
            end else if (ofmap_valid_o && ofmap_ready_i) begin
                ofmap_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_psum_drain.sv
// Directed bench for psum_drain: hand-computed ofmap sequences, handshake timing,
// error flag behaviour and reset abort.
module tb_psum_drain;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start_i;
    logic [3:0]  cfg_len_i;
    logic [3:0]  cfg_passes_i;
    logic [4:0]  cfg_shift_i;
    logic [31:0] psum_i;
    logic        psum_en_i;
    logic [7:0]  ofmap_o;
    logic        ofmap_valid_o;
    logic        ofmap_ready_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    int n_total = 0;
    int n_pass  = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    psum_drain dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_start_i   (cfg_start_i),
        .cfg_len_i     (cfg_len_i),
        .cfg_passes_i  (cfg_passes_i),
        .cfg_shift_i   (cfg_shift_i),
        .psum_i        (psum_i),
        .psum_en_i     (psum_en_i),
        .ofmap_o       (ofmap_o),
        .ofmap_valid_o (ofmap_valid_o),
        .ofmap_ready_i (ofmap_ready_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input string tag, input logic [3:0] len,
                             input logic [3:0] passes, input logic [4:0] shift);
        cfg_len_i    = len;
        cfg_passes_i = passes;
        cfg_shift_i  = shift;
        cfg_start_i  = 1'b1;
        tick();
        cfg_start_i  = 1'b0;
        check({tag, "_busy"}, 32'(busy_o), 32'd1);
    endtask

    task automatic send(input logic [31:0] v);
        psum_i    = v;
        psum_en_i = 1'b1;
        tick();
        psum_en_i = 1'b0;
    endtask

    // Drains n elements against exp_q; optionally holds ready low 3 cycles on element stall_at.
    task automatic drain(input string tag, input int n, input int stall_at);
        int got = 0;
        int cyc = 0;
        int stall = 0;
        logic [7:0] held;
        while (got < n && cyc < 200) begin
            if (got == stall_at && stall < 3 && ofmap_valid_o) begin
                ofmap_ready_i = 1'b0;
                held = ofmap_o;
                tick();
                stall++;
                check({tag, "_hold_vld"}, 32'(ofmap_valid_o), 32'd1);
                check({tag, "_hold_dat"}, 32'(ofmap_o), 32'(held));
            end else begin
                ofmap_ready_i = 1'b1;
                if (ofmap_valid_o) begin
                    check({tag, "_dat"}, 32'(ofmap_o), 32'(exp_q.pop_front()));
                    got++;
                end
                tick();
            end
            cyc++;
        end
        check({tag, "_count"}, 32'(got), 32'(n));
        check({tag, "_done"}, 32'(done_o), 32'd1);
        check({tag, "_idle"}, 32'(busy_o), 32'd0);
        ofmap_ready_i = 1'b0;
        tick();
        check({tag, "_done_pulse"}, 32'(done_o), 32'd0);
        check({tag, "_vld_off"}, 32'(ofmap_valid_o), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        cfg_start_i   = 1'b0;
        cfg_len_i     = '0;
        cfg_passes_i  = '0;
        cfg_shift_i   = '0;
        psum_i        = '0;
        psum_en_i     = 1'b0;
        ofmap_ready_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_vld",   32'(ofmap_valid_o), 32'd0);
        check("rst_busy",  32'(busy_o), 32'd0);
        check("rst_done",  32'(done_o), 32'd0);
        check("rst_err",   32'(err_o), 32'd0);
        check("rst_ofmap", 32'(ofmap_o), 32'd0);

        // Single pass: clamp high and ReLU, plus first-valid latency.
        start_job("single", 4'd3, 4'd0, 5'd0);
        send(32'd10);
        send(32'd20);
        send(32'd300);
        send(-32'sd5);
        check("single_lat0", 32'(ofmap_valid_o), 32'd0);
        tick();
        check("single_lat1", 32'(ofmap_valid_o), 32'd1);
        exp_q = '{8'd10, 8'd20, 8'd255, 8'd0};
        drain("single", 4, -1);

        // Multi-pass with gaps and an ignored mid-job start.
        start_job("multi", 4'd1, 4'd2, 5'd1);
        for (int p = 0; p < 3; p++) begin
            send(32'd100);
            tick();
            if (p == 1) begin
                cfg_len_i   = 4'd0;
                cfg_start_i = 1'b1;
                tick();
                cfg_start_i = 1'b0;
            end
            send(-32'sd50);
            for (int g = 0; g < p; g++) tick();
        end
        exp_q = '{8'd150, 8'd0};
        drain("multi", 2, -1);

        // Backpressure mid-drain.
        start_job("bp", 4'd5, 4'd0, 5'd2);
        send(32'd40);
        send(32'd80);
        send(32'd1000);
        send(-32'sd8);
        send(32'd12);
        send(32'd4096);
        exp_q = '{8'd10, 8'd20, 8'd250, 8'd0, 8'd3, 8'd255};
        drain("bp", 6, 2);

        // Stray psums: in IDLE, coincident with start, and during DRAIN.
        psum_i    = 32'd999;
        psum_en_i = 1'b1;
        tick();
        psum_en_i = 1'b0;
        check("stray_idle_err", 32'(err_o), 32'd1);
        psum_i    = 32'd55;
        psum_en_i = 1'b1;
        start_job("stray_start", 4'd1, 4'd0, 5'd0);
        psum_en_i = 1'b0;
        check("stray_start_err", 32'(err_o), 32'd0);
        send(32'd7);
        send(32'd9);
        ofmap_ready_i = 1'b1;
        psum_i    = 32'd123;
        psum_en_i = 1'b1;
        tick();
        psum_en_i = 1'b0;
        check("stray_drain_err", 32'(err_o), 32'd1);
        exp_q = '{8'd7, 8'd9};
        drain("stray", 2, -1);
        check("stray_err_sticky", 32'(err_o), 32'd1);

        // Reset mid-ACCUM, then a fresh job.
        start_job("abort", 4'd3, 4'd0, 5'd0);
        send(32'd1);
        send(32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_vld",  32'(ofmap_valid_o), 32'd0);
        check("abort_err",  32'(err_o), 32'd0);
        start_job("fresh", 4'd3, 4'd0, 5'd0);
        send(32'd50);
        send(32'd60);
        send(32'd70);
        send(32'd80);
        exp_q = '{8'd50, 8'd60, 8'd70, 8'd80};
        drain("fresh", 4, -1);

        // Wrap: 0x7FFFFFFF + 1 becomes negative and ReLU clamps to 0.
        start_job("wrap", 4'd0, 4'd1, 5'd0);
        send(32'h7FFF_FFFF);
        send(32'd1);
        exp_q = '{8'd0};
        drain("wrap", 1, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
